// File: rtl/if_id_register.sv
// IF/ID pipeline register: captures the fetched instruction and its PC every
// non-reset cycle and presents them, plus a valid flag and opcode, to decode.
module if_id_register #(
  parameter int                     INSTR_WIDTH = 16,
  parameter int                     PC_WIDTH    = 16,
  parameter logic [INSTR_WIDTH-1:0] RESET_INSTR = '0,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INSTR_WIDTH-1:0] instruction_in,
  input  logic [PC_WIDTH-1:0]    pc_in,
  output logic [INSTR_WIDTH-1:0] instruction_out,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic                   valid_out,
  output logic [3:0]             opcode_out
);

  // Reset wins over capture, so inputs present on a reset edge are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      instruction_out <= RESET_INSTR;
      pc_out          <= RESET_PC;
      valid_out       <= 1'b0;
    end else begin
      instruction_out <= instruction_in;
      pc_out          <= pc_in;
      valid_out       <= 1'b1;
    end
  end

  // Opcode is a pure slice of the register, so it carries no extra latency.
  assign opcode_out = instruction_out[INSTR_WIDTH-1 -: 4];

endmodule

// File: tb/tb_if_id_register.sv
// Directed bench for if_id_register: a vector table for reset and capture,
// then hand-written sequences for mid-cycle stability, reset priority and streaming.
module tb_if_id_register;

  logic        clk;
  logic        reset;
  logic [15:0] instruction_in;
  logic [15:0] pc_in;
  logic [15:0] instruction_out;
  logic [15:0] pc_out;
  logic        valid_out;
  logic [3:0]  opcode_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] exp_instr;
    logic [15:0] exp_pc;
    logic        exp_valid;
    logic [3:0]  exp_opcode;
  } vec_t;

  vec_t vectors[4];

  if_id_register dut (
    .clk             (clk),
    .reset           (reset),
    .instruction_in  (instruction_in),
    .pc_in           (pc_in),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .valid_out       (valid_out),
    .opcode_out      (opcode_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; results are sampled 1 ns after the rising edge.
  task automatic applyStimulus(input logic rst, input logic [15:0] instr, input logic [15:0] pc);
    @(negedge clk);
    reset          = rst;
    instruction_in = instr;
    pc_in          = pc;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] exp_instr,
                             input logic [15:0] exp_pc, input logic exp_valid,
                             input logic [3:0] exp_opcode);
    checks++;
    if (instruction_out !== exp_instr) begin
      errors++;
      $display("[TB] FAIL %s instruction_out: got %h expected %h", name, instruction_out, exp_instr);
    end
    checks++;
    if (pc_out !== exp_pc) begin
      errors++;
      $display("[TB] FAIL %s pc_out: got %h expected %h", name, pc_out, exp_pc);
    end
    checks++;
    if (valid_out !== exp_valid) begin
      errors++;
      $display("[TB] FAIL %s valid_out: got %b expected %b", name, valid_out, exp_valid);
    end
    checks++;
    if (opcode_out !== exp_opcode) begin
      errors++;
      $display("[TB] FAIL %s opcode_out: got %h expected %h", name, opcode_out, exp_opcode);
    end
  endtask

  initial begin
    logic [15:0] bb_instr;
    logic [15:0] bb_pc;

    reset          = 1'b1;
    instruction_in = 16'h9C3E;
    pc_in          = 16'h7A51;

    vectors[0] = '{"reset",        1'b1, 16'h9C3E, 16'h7A51, 16'h0000, 16'h0000, 1'b0, 4'h0};
    vectors[1] = '{"reset_hold",   1'b1, 16'h4242, 16'hBEEF, 16'h0000, 16'h0000, 1'b0, 4'h0};
    vectors[2] = '{"basic_capture",1'b0, 16'h1234, 16'h0001, 16'h1234, 16'h0001, 1'b1, 4'h1};
    vectors[3] = '{"update",       1'b0, 16'h5678, 16'h0011, 16'h5678, 16'h0011, 1'b1, 4'h5};

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vectors[i].rst, vectors[i].instr, vectors[i].pc);
      checkOutput(vectors[i].name, vectors[i].exp_instr, vectors[i].exp_pc,
                  vectors[i].exp_valid, vectors[i].exp_opcode);
    end

    // Inputs wiggle between edges; outputs must hold 5678 until the next rising edge.
    @(negedge clk);
    instruction_in = 16'hABCD;
    #1;
    checkOutput("midcycle_hold_a", 16'h5678, 16'h0011, 1'b1, 4'h5);
    pc_in = 16'h0022;
    #2;
    checkOutput("midcycle_hold_b", 16'h5678, 16'h0011, 1'b1, 4'h5);
    @(posedge clk);
    #1;
    checkOutput("midcycle_capture", 16'hABCD, 16'h0022, 1'b1, 4'hA);

    // Raising reset between edges must not disturb outputs until the edge.
    @(negedge clk);
    reset          = 1'b1;
    instruction_in = 16'hFFFF;
    pc_in          = 16'hFFFF;
    #1;
    checkOutput("reset_no_async", 16'hABCD, 16'h0022, 1'b1, 4'hA);
    @(posedge clk);
    #1;
    checkOutput("reset_priority", 16'h0000, 16'h0000, 1'b0, 4'h0);

    applyStimulus(1'b0, 16'hFFFF, 16'hFFFF);
    checkOutput("post_reset_all_ones", 16'hFFFF, 16'hFFFF, 1'b1, 4'hF);

    // Streaming: each edge's result must be the pair driven just before it.
    for (int i = 0; i < 8; i++) begin
      bb_instr = 16'($urandom);
      bb_pc    = 16'($urandom);
      applyStimulus(1'b0, bb_instr, bb_pc);
      checkOutput($sformatf("back_to_back_%0d", i), bb_instr, bb_pc, 1'b1, bb_instr[15:12]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_register.md
IF_ID_REGISTER -- requirements
Module: if_id_register

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-002 Parameter INSTR_WIDTH, default 16, SHALL set the instruction bus width.
REQ-003 Parameter PC_WIDTH, default 16, SHALL set the PC bus width.
REQ-004 Parameter RESET_INSTR, default all-zero (NOP encoding), SHALL set the instruction_out reset value.
REQ-005 Parameter RESET_PC, default all-zero, SHALL set the pc_out reset value.
REQ-006 clk  input  1  SHALL be the clock; all state updates on the rising edge.
REQ-007 reset  input  1  SHALL be the synchronous, active-high reset, sampled only on the rising edge of clk.
REQ-008 instruction_in  input  INSTR_WIDTH  SHALL be the instruction fetched by the IF stage.
REQ-009 pc_in  input  PC_WIDTH  SHALL be the PC associated with instruction_in.
REQ-010 instruction_out  output  INSTR_WIDTH  SHALL be the registered instruction presented to the ID stage.
REQ-011 pc_out  output  PC_WIDTH  SHALL be the registered PC presented to the ID stage.
REQ-012 valid_out  output  1  SHALL indicate that the ID-stage outputs hold a captured instruction and not a reset value.
REQ-013 opcode_out  output  4  SHALL equal instruction_out[INSTR_WIDTH-1:INSTR_WIDTH-4], decoded combinationally from the register.

Function
REQ-014 On every rising edge of clk with reset low, instruction_out SHALL load instruction_in and pc_out SHALL load pc_in.
REQ-015 Latency SHALL be exactly one clock: a value present at edge N SHALL appear on the outputs after edge N and hold until edge N+1.
REQ-016 Outputs SHALL change only on a rising clk edge; input changes between edges SHALL have no effect on the outputs.
REQ-017 There SHALL be no stall, flush or handshake; the register captures unconditionally every non-reset cycle.
REQ-018 valid_out SHALL be 0 under reset and SHALL become 1 on the first rising edge with reset low, then stay 1 until the next reset.
REQ-019 opcode_out SHALL track instruction_out with no additional latency.
REQ-020 All outputs SHALL be driven directly from flops or from pure combinational slices of them, with no combinational path from any input to any output.
REQ-021 Values SHALL be captured bit-exact with no arithmetic, sign extension or truncation; a PC of all-ones SHALL pass through unchanged.

Reset
REQ-022 On a rising edge with reset high, outputs SHALL be set as follows: instruction_out=RESET_INSTR, pc_out=RESET_PC, valid_out=0, and opcode_out SHALL follow instruction_out.
REQ-023 Reset SHALL take priority over data capture on the same edge; inputs present at that edge SHALL be discarded.
REQ-024 Reset asserted mid-stream SHALL clear the outputs at the next rising edge, with no asynchronous effect before that edge.
REQ-025 Before the first rising edge with reset high, output values SHALL be unspecified, and a bench SHALL NOT check them.
REQ-026 After reset deasserts, the first rising edge SHALL capture the inputs normally.

Verification
REQ-027 Reset check: drive reset=1 for one rising edge with arbitrary inputs -> instruction_out=0000, pc_out=0000, valid_out=0, opcode_out=0.
REQ-028 Basic capture: after reset, drive instruction_in=1234 and pc_in=0001 before an edge -> after that edge, instruction_out=1234, pc_out=0001, opcode_out=1, valid_out=1.
REQ-029 Update: next drive instruction_in=5678 and pc_in=0011 -> after the following edge, instruction_out=5678, pc_out=0011, opcode_out=5.
REQ-030 Mid-cycle stability: change instruction_in to ABCD between edges -> instruction_out stays 5678 until the next rising edge, then becomes ABCD.
REQ-031 Reset priority: reset=1 with instruction_in=FFFF and pc_in=FFFF -> after the edge, outputs are 0000/0000 and valid_out=0; after reset deasserts, the next edge captures FFFF/FFFF.
REQ-032 Back-to-back: apply a new pair every cycle for 8 cycles -> each output pair equals the input pair from exactly one edge earlier.
